// File: rtl/ahb_params_pkg.sv
// Shared AHB encodings and arbiter configuration types.
// Imported by the arbiter top and its winner-select sub-module.
package ahb_params_pkg;

    localparam int NO_OF_MASTERS = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Beats still to come after the NONSEQ of a fixed-length burst.
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        logic [3:0] n;
        case (hburst)
            HBURST_WRAP4, HBURST_INCR4:   n = 4'd3;
            HBURST_WRAP8, HBURST_INCR8:   n = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: n = 4'd15;
            default:                      n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ahb_arb_prio_sel.sv
// Combinational winner select: fixed priority or round-robin
// starting just above the last granted master.
module ahb_arb_prio_sel
    import ahb_params_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] last_grant,
    input  arb_mode_e    mode,
    output logic [N-1:0] winner
);

    int   idx;
    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (mode == ARB_RR) ? (int'(last_grant) + 1 + k) % N : k;
            if (!found && eligible[idx[W-1:0]]) begin
                winner[idx[W-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter_n.sv
// N-master AHB arbiter with lock, fixed-burst hold and SPLIT masking.
// Grant, owner and lock indication are all registered on HREADY edges.
module ahb_arbiter_n #(
    parameter int NO_OF_MASTERS  = ahb_params_pkg::NO_OF_MASTERS,
    parameter int ARB_MODE       = 1,
    parameter int DEFAULT_MASTER = 0,
    localparam int W = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [NO_OF_MASTERS-1:0] HBUSREQ,
    input  logic [NO_OF_MASTERS-1:0] HLOCK,
    input  logic [NO_OF_MASTERS-1:0] HSPLIT,
    input  logic [1:0]               HTRANS,
    input  logic [2:0]               HBURST,
    input  logic                     HREADY,
    input  logic [1:0]               HRESP,
    output logic [NO_OF_MASTERS-1:0] HGRANT,
    output logic [W-1:0]             HMASTER,
    output logic                     HMASTLOCK
);
    import ahb_params_pkg::*;

    localparam arb_mode_e MODE = (ARB_MODE == 0) ? ARB_FIXED : ARB_RR;
    localparam logic [NO_OF_MASTERS-1:0] DEF_GRANT =
        {{(NO_OF_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
    localparam logic [W-1:0] DEF_IDX = W'(DEFAULT_MASTER);

    logic [NO_OF_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [NO_OF_MASTERS-1:0] split_mask_q, split_mask_d;
    logic [NO_OF_MASTERS-1:0] eligible, winner;
    logic [W-1:0]             hmaster_q, hmaster_d;
    logic [W-1:0]             last_grant_q, last_grant_d;
    logic [W-1:0]             gidx, widx;
    logic                     hmastlock_q, hmastlock_d;
    logic [3:0]               beat_cnt_q, beat_cnt_d;
    logic                     split_set, hold;

    ahb_arb_prio_sel #(
        .N (NO_OF_MASTERS),
        .W (W)
    ) u_sel (
        .eligible   (eligible),
        .last_grant (last_grant_q),
        .mode       (MODE),
        .winner     (winner)
    );

    always_comb begin
        split_set    = HREADY && (HRESP == HRESP_SPLIT);
        split_mask_d = split_mask_q & ~HSPLIT;
        if (split_set) split_mask_d[hmaster_q] = 1'b1;
        beat_cnt_d = beat_cnt_q;
        if (HREADY) begin
            if (HRESP != HRESP_OKAY)
                beat_cnt_d = '0;
            else if (HTRANS == HTRANS_NONSEQ)
                beat_cnt_d = burst_beats(HBURST);
            else if (HTRANS == HTRANS_SEQ && beat_cnt_q != '0)
                beat_cnt_d = beat_cnt_q - 4'd1;
        end
    end

    // A freshly split master is excluded on the very edge it splits.
    assign eligible = HBUSREQ & ~split_mask_d;

    always_comb begin
        gidx = '0;
        widx = '0;
        for (int i = 0; i < NO_OF_MASTERS; i++) begin
            if (hgrant_q[i]) gidx = W'(i);
            if (winner[i])   widx = W'(i);
        end
        hold         = !split_set && (HLOCK[gidx] || beat_cnt_d != '0);
        hgrant_d     = hgrant_q;
        hmaster_d    = hmaster_q;
        hmastlock_d  = hmastlock_q;
        last_grant_d = last_grant_q;
        if (HREADY) begin
            hmaster_d   = gidx;
            hmastlock_d = HLOCK[gidx];
            if (!hold) begin
                if (eligible == '0) begin
                    hgrant_d = DEF_GRANT;
                end else begin
                    hgrant_d = winner;
                    if (winner != hgrant_q) last_grant_d = widx;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hgrant_q     <= DEF_GRANT;
            hmaster_q    <= DEF_IDX;
            hmastlock_q  <= 1'b0;
            split_mask_q <= '0;
            beat_cnt_q   <= '0;
            last_grant_q <= DEF_IDX;
        end else begin
            hgrant_q     <= hgrant_d;
            hmaster_q    <= hmaster_d;
            hmastlock_q  <= hmastlock_d;
            split_mask_q <= split_mask_d;
            beat_cnt_q   <= beat_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign HGRANT    = hgrant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_n.sv
// Scoreboard bench: round-robin and fixed-priority arbiters on shared
// inputs, checked against a behavioural model plus directed scenarios.
module tb_ahb_arbiter_n;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] busreq, lock, split;
    logic [1:0] trans, resp;
    logic [2:0] burst;
    logic       ready;
    logic [3:0] rr_grant, fx_grant;
    logic [1:0] rr_master, fx_master;
    logic       rr_lock, fx_lock;

    always #5 clk = ~clk;

    ahb_arbiter_n #(
        .NO_OF_MASTERS (4), .ARB_MODE (1), .DEFAULT_MASTER (0)
    ) u_rr (
        .HCLK (clk), .HRESETn (rst_n), .HBUSREQ (busreq),
        .HLOCK (lock), .HSPLIT (split), .HTRANS (trans),
        .HBURST (burst), .HREADY (ready), .HRESP (resp),
        .HGRANT (rr_grant), .HMASTER (rr_master),
        .HMASTLOCK (rr_lock)
    );

    ahb_arbiter_n #(
        .NO_OF_MASTERS (4), .ARB_MODE (0), .DEFAULT_MASTER (2)
    ) u_fx (
        .HCLK (clk), .HRESETn (rst_n), .HBUSREQ (busreq),
        .HLOCK (lock), .HSPLIT (split), .HTRANS (trans),
        .HBURST (burst), .HREADY (ready), .HRESP (resp),
        .HGRANT (fx_grant), .HMASTER (fx_master),
        .HMASTLOCK (fx_lock)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [31:0] got,
                                logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    typedef struct {
        int   grant;
        int   master;
        bit   lck;
        bit   [3:0] mask;
        int   beats;
        int   last;
        bit   rr;
        int   dflt;
    } mdl_t;

    typedef struct {
        int g0, g1, m0, m1;
        bit l0, l1;
    } exp_t;

    mdl_t m[2];
    exp_t q[$];

    function automatic void mdl_reset();
        m[0].rr = 1'b1; m[0].dflt = 0;
        m[1].rr = 1'b0; m[1].dflt = 2;
        for (int d = 0; d < 2; d++) begin
            m[d].grant = m[d].dflt; m[d].master = m[d].dflt;
            m[d].lck = 1'b0; m[d].mask = '0;
            m[d].beats = 0; m[d].last = m[d].dflt;
        end
    endfunction

    function automatic void mdl_step(int d);
        int      g, w;
        bit      sp, hold;
        bit [3:0] el;
        int      order[$];
        g = m[d].grant;
        m[d].mask = m[d].mask & ~split;
        if (!ready) return;
        sp = (resp == 2'b11);
        if (sp) m[d].mask[m[d].master] = 1'b1;
        if (resp != 2'b00) m[d].beats = 0;
        else if (trans == 2'b10)
            m[d].beats = (burst >= 6) ? 15 : (burst >= 4) ? 7 :
                         (burst >= 2) ? 3 : 0;
        else if (trans == 2'b11 && m[d].beats > 0) m[d].beats--;
        hold = !sp && (lock[g] || m[d].beats > 0);
        m[d].master = g;
        m[d].lck = lock[g];
        if (hold) return;
        el = busreq & ~m[d].mask;
        w = m[d].dflt;
        for (int k = 0; k < 4; k++)
            order.push_back(m[d].rr ? (m[d].last + 1 + k) % 4 : k);
        foreach (order[i])
            if (el[order[i]] && w == m[d].dflt && el != 0) begin
                w = order[i];
                break;
            end
        if (el != 0 && w != g) m[d].last = w;
        m[d].grant = w;
    endfunction

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        mdl_step(0);
        mdl_step(1);
        e.g0 = m[0].grant; e.m0 = m[0].master; e.l0 = m[0].lck;
        e.g1 = m[1].grant; e.m1 = m[1].master; e.l1 = m[1].lck;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drv(input logic [3:0] b, input logic [3:0] l,
                       input logic [1:0] t, input logic [2:0] bu,
                       input logic [1:0] r, input logic rd);
        busreq = b; lock = l; split = '0;
        trans = t; burst = bu; resp = r; ready = rd;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rr_grant", rr_grant, 32'(1 << e.g0));
                chk("rr_master", rr_master, e.m0);
                chk("rr_lock", rr_lock, e.l0);
                chk("fx_grant", fx_grant, 32'(1 << e.g1));
                chk("fx_master", fx_master, e.m1);
                chk("fx_lock", fx_lock, e.l1);
            end
        end
    end

    initial begin : stim
        int rot[4] = '{2, 4, 8, 1};
        logic [1:0] seq_rd[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int seq_g[4] = '{4, 4, 4, 1};
        drv(4'h0, 4'h0, 2'b00, 3'b000, 2'b00, 1'b1);
        mdl_reset();
        repeat (2) @(negedge clk);
        chk("rst_rr_grant", rr_grant, 1);
        chk("rst_rr_master", rr_master, 0);
        chk("rst_fx_grant", fx_grant, 4);
        chk("rst_fx_master", fx_master, 2);
        chk("rst_fx_lock", fx_lock, 0);
        rst_n = 1'b1;

        drv(4'hF, 4'h0, 2'b10, 3'b000, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_rotate", rr_grant, rot[i]);
        end

        drv(4'hE, 4'h0, 2'b10, 3'b000, 2'b00, 1'b1);
        cyc();
        chk("fx_prio_1110", fx_grant, 4'h2);
        busreq = 4'hC;
        cyc();
        chk("fx_prio_1100", fx_grant, 4'h4);

        drv(4'hF, 4'h0, 2'b10, 3'b011, 2'b00, 1'b1);
        cyc();
        chk("incr4_nonseq", fx_grant, 4'h4);
        for (int i = 0; i < 4; i++) begin
            drv(4'hF, 4'h0, 2'b11, 3'b011, 2'b00, seq_rd[i][0]);
            cyc();
            chk("incr4_beat", fx_grant, seq_g[i]);
        end

        drv(4'h2, 4'h0, 2'b00, 3'b000, 2'b00, 1'b1);
        cyc();
        chk("lock_setup", fx_grant, 4'h2);
        for (int i = 0; i < 3; i++) begin
            drv(4'hF, 4'h2, 2'b10, 3'b000, 2'b00, 1'b1);
            cyc();
            chk("lock_grant", fx_grant, 4'h2);
            chk("lock_mastlock", fx_lock, 1);
        end
        lock = 4'h0;
        cyc();
        chk("lock_release", fx_grant, 4'h1);

        drv(4'h8, 4'h0, 2'b10, 3'b000, 2'b00, 1'b1);
        cyc();
        cyc();
        chk("split_owner", rr_master, 3);
        resp = 2'b11;
        cyc();
        chk("split_rr_default", rr_grant, 4'h1);
        chk("split_fx_default", fx_grant, 4'h4);
        resp = 2'b00;
        cyc();
        chk("split_masked", rr_grant, 4'h1);
        split = 4'h8;
        cyc();
        chk("split_clear_rr", rr_grant, 4'h8);
        chk("split_clear_fx", fx_grant, 4'h8);
        split = 4'h0;

        for (int i = 0; i < 1500; i++) begin
            busreq = 4'($urandom);
            lock   = 4'($urandom & $urandom & $urandom);
            split  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            trans  = 2'($urandom);
            burst  = 3'($urandom);
            resp   = ($urandom_range(0, 7) < 6) ? 2'b00 : 2'($urandom);
            ready  = ($urandom_range(0, 3) != 0);
            cyc();
        end

        drv(4'hF, 4'h0, 2'b10, 3'b101, 2'b00, 1'b1);
        cyc();
        drv(4'hF, 4'h0, 2'b11, 3'b101, 2'b00, 1'b1);
        cyc();
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rr_grant", rr_grant, 1);
        chk("midrst_rr_master", rr_master, 0);
        chk("midrst_rr_lock", rr_lock, 0);
        chk("midrst_fx_grant", fx_grant, 4);
        chk("midrst_fx_master", fx_master, 2);
        mdl_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drv(4'h2, 4'h0, 2'b00, 3'b000, 2'b00, 1'b1);
        cyc();
        chk("postrst_rr", rr_grant, 4'h2);
        chk("postrst_fx", fx_grant, 4'h2);

        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter_n.md
AHB_ARBITER_N -- requirements
Module: ahb_arbiter_n

Interface
REQ-001 Parameter NO_OF_MASTERS, default 4: number of masters, legal range 2..16.
REQ-002 Parameter ARB_MODE, default 1: 0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-003 Parameter DEFAULT_MASTER, default 0: master granted when no eligible request exists.
REQ-004 Port HCLK, input, 1: clock; all state updates on rising edge.
REQ-005 Port HRESETn, input, 1: reset, asynchronous, active-low.
REQ-006 Port HBUSREQ, input, NO_OF_MASTERS: per-master bus request.
REQ-007 Port HLOCK, input, NO_OF_MASTERS: per-master locked-transfer request.
REQ-008 Port HSPLIT, input, NO_OF_MASTERS: split-completion pulses from slaves (OR-combined).
REQ-009 Port HTRANS, input, 2: transfer type of current bus owner.
REQ-010 Port HBURST, input, 3: burst type of current bus owner.
REQ-011 Port HREADY, input, 1: transfer-complete strobe.
REQ-012 Port HRESP, input, 2: slave response (OKAY 00, ERROR 01, RETRY 10, SPLIT 11).
REQ-013 Port HGRANT, output, NO_OF_MASTERS: registered one-hot grant.
REQ-014 Port HMASTER, output, $clog2(NO_OF_MASTERS): registered index of address-phase owner.
REQ-015 Port HMASTLOCK, output, 1: registered locked-sequence indication.

Function
REQ-016 HGRANT SHALL be exactly one-hot in every cycle after reset.
REQ-017 HGRANT SHALL update only on a rising edge where HREADY=1; otherwise it holds.
REQ-018 On that HREADY=1 edge HMASTER SHALL load the index of the HGRANT value current before the edge, and HMASTLOCK SHALL load HLOCK[that index].
REQ-019 Eligible set = HBUSREQ AND NOT split_mask.
REQ-020 ARB_MODE=0: winner = lowest-index eligible master.
REQ-021 ARB_MODE=1: winner = first eligible master searching from last_grant+1 upward, wrapping at NO_OF_MASTERS-1 to 0.
REQ-022 last_grant SHALL update to the new winner only when the grant actually changes to a requesting master.
REQ-023 Empty eligible set: grant DEFAULT_MASTER, even if it is split-masked.
REQ-024 Hold (no re-arbitration): HLOCK[granted]=1, or the fixed-length burst beat counter is non-zero.
REQ-025 Beat counter: on HREADY=1 with HTRANS=NONSEQ, load 3/7/15 for INCR4/WRAP4, INCR8/WRAP8, INCR16/WRAP16; load 0 for SINGLE/INCR.
REQ-026 Beat counter decrements on HREADY=1 with HTRANS=SEQ, saturates at 0, and is cleared by HRESP ERROR, RETRY or SPLIT.
REQ-027 Grant SHALL be released on the last beat, when the counter equals 1 and SEQ completes.
REQ-028 Undefined-length INCR: no hold; re-arbitrate every HREADY=1 edge.
REQ-029 split_mask[HMASTER] SHALL set on HREADY=1 with HRESP=SPLIT; hold is overridden and re-arbitration occurs that edge.
REQ-030 split_mask[i] SHALL clear when HSPLIT[i]=1; a simultaneous set and clear of the same bit resolves to set.
REQ-031 RETRY SHALL NOT alter split_mask or last_grant.

Reset
REQ-032 HRESETn low SHALL asynchronously force HGRANT = one-hot(DEFAULT_MASTER), HMASTER = DEFAULT_MASTER, HMASTLOCK = 0, split_mask = 0, beat counter = 0, last_grant = DEFAULT_MASTER.
REQ-033 Reset mid-burst or mid-lock SHALL abandon the hold; first arbitration follows the first HREADY=1 edge after release.

Structure
REQ-034 ahb_params_pkg SHALL hold NO_OF_MASTERS, the HTRANS/HBURST/HRESP encodings and the ARB_MODE enum.
REQ-035 Winner selection SHALL be a combinational sub-module ahb_arb_prio_sel (inputs: eligible vector, last_grant, mode; output: one-hot winner).

Verification
REQ-036 ARB_MODE=1, HBUSREQ=1111, HREADY=1, SINGLE transfers -> HGRANT cycles 0010, 0100, 1000, 0001.
REQ-037 ARB_MODE=0, HBUSREQ=1110 -> HGRANT=0010; then HBUSREQ=1100 -> HGRANT=0100 on the next HREADY=1 edge.
REQ-038 Master 2 issues INCR4 with HBUSREQ=1111 and one HREADY=0 wait state -> grant held through 4 beats, changes only after the last SEQ completes.
REQ-039 Master 1 HLOCK=1 for 3 transfers -> HGRANT stays 0010 and HMASTLOCK=1; released on the first HREADY edge after HLOCK=0.
REQ-040 HMASTER=3, HRESP=SPLIT -> split_mask=1000 and master 3 not granted despite HBUSREQ[3]=1; HSPLIT=1000 -> master 3 granted again; all-masked -> DEFAULT_MASTER.
REQ-041 HRESETn asserted mid-INCR8 -> outputs immediately take REQ-032 values.
